// File: rtl/multicycle_alu.sv
// Handshaked multi-cycle ALU: single-cycle logic ops, iterative shift-add multiply,
// bit-serial shift/rotate. Results and flags load together on the DONE edge.
module multicycle_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned      CW       = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL    = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_FWD  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_MULT = 3'b100,
        OP_SL   = 3'b101,
        OP_SRA  = 3'b110,
        OP_ROR  = 3'b111
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_d, zero_d, carry_d, overflow_d;
    logic [WIDTH-1:0] result_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] mac_c, shifted_c, res_c;
    logic [CW-1:0]    n_c;
    logic             fin_c, cout_c, ovf_c;

    // work_q holds operand A, the multiplicand (shifted left) or the shift value.
    assign sum_c = {1'b0, work_q} + {1'b0, opb_q};
    assign mac_c = acc_q + (opb_q[0] ? work_q : '0);
    assign busy  = (state_q == RUN);

    always_comb begin
        case (op_q)
            OP_SL:   shifted_c = {work_q[WIDTH-2:0], 1'b0};
            OP_SRA:  shifted_c = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            default: shifted_c = {work_q[0], work_q[WIDTH-1:1]};
        endcase
    end

    // Effective shift/rotate count, resolved once at accept time.
    always_comb begin
        case (select)
            OP_SL, OP_SRA: n_c = (data2 >= W_VAL) ? CNT_MAX : CW'(data2);
            OP_ROR:        n_c = CW'(data2 % W_VAL);
            default:       n_c = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        work_d     = work_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        result_d   = result;
        zero_d     = zero;
        carry_d    = carry;
        overflow_d = overflow;
        fin_c      = 1'b0;
        res_c      = '0;
        cout_c     = 1'b0;
        ovf_c      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op_t'(select);
                    work_d  = data1;
                    opb_d   = data2;
                    acc_d   = '0;
                    cnt_d   = n_c;
                end
            end
            RUN: begin
                case (op_q)
                    OP_FWD: begin
                        fin_c = 1'b1;
                        res_c = opb_q;
                    end
                    OP_ADD: begin
                        fin_c  = 1'b1;
                        res_c  = sum_c[WIDTH-1:0];
                        cout_c = sum_c[WIDTH];
                        ovf_c  = (work_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                 (sum_c[WIDTH-1] != work_q[WIDTH-1]);
                    end
                    OP_AND: begin
                        fin_c = 1'b1;
                        res_c = work_q & opb_q;
                    end
                    OP_OR: begin
                        fin_c = 1'b1;
                        res_c = work_q | opb_q;
                    end
                    OP_MULT: begin
                        // Low WIDTH bits of a signed product equal those of the unsigned one.
                        acc_d  = mac_c;
                        work_d = {work_q[WIDTH-2:0], 1'b0};
                        opb_d  = {1'b0, opb_q[WIDTH-1:1]};
                        cnt_d  = cnt_q + CW'(1);
                        if (cnt_q == CNT_LAST) begin
                            fin_c = 1'b1;
                            res_c = mac_c;
                        end
                    end
                    default: begin
                        if (cnt_q == '0) begin
                            fin_c = 1'b1;
                            res_c = work_q;
                        end else begin
                            work_d = shifted_c;
                            cnt_d  = cnt_q - CW'(1);
                        end
                    end
                endcase

                if (fin_c) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    done_d     = 1'b1;
                    result_d   = res_c;
                    zero_d     = (res_c == '0);
                    carry_d    = cout_c;
                    overflow_d = ovf_c;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_FWD;
            work_q   <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            done     <= done_d;
            result   <= result_d;
            zero     <= zero_d;
            carry    <= carry_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked successor to the single-cycle 8-bit datapath ALU. Same 3-bit operation encoding. Adds:
- registered results and flags;
- an iterative signed multiplier;
- bit-serial shift/rotate engines;
- a START/BUSY/DONE handshake, so the CPU control unit can stall on long operations instead of relying on fixed `#` delays.

It sits between the register file read ports and the write-back mux.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- SELECT  input  3  op code: 000 FORWARD, 001 ADD, 010 AND, 011 OR, 100 MULT, 101 SL, 110 SRA, 111 ROR.
- DATA1  input  WIDTH  operand A / shift source.
- DATA2  input  WIDTH  operand B / shift amount (unsigned).
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse: RESULT and flags are valid and updated.
- RESULT  output  WIDTH  registered result; held until the next DONE.
- ZERO  output  1  RESULT == 0, for every op.
- CARRY  output  1  ADD carry-out; 0 for all other ops.
- OVERFLOW  output  1  ADD signed overflow; 0 for all other ops.

## Operation
- FSM states are IDLE and RUN. DONE is a registered pulse asserted on the RUN→IDLE edge. BUSY = (state == RUN).
- **Accept:** in IDLE, START=1 at edge k latches SELECT, DATA1, DATA2 into internal registers and enters RUN. Later input changes do not affect the operation.
- **FORWARD / ADD / AND / OR:** result = DATA2, A+B (mod 2^WIDTH), A&B, A|B.
  - CARRY = bit WIDTH of the (WIDTH+1)-bit sum.
  - OVERFLOW = (A[msb] == B[msb]) && (sum[msb] != A[msb]).
- **MULT:** signed two's-complement product, truncated to the low WIDTH bits (equal to the low bits of the exact product). Computed as iterative radix-2 shift-add, one partial product per cycle, with a cycle counter 0..WIDTH-1.
- **SL / SRA:** one bit per cycle.
  - Effective count n = min(DATA2, WIDTH).
  - SL shifts in 0. SRA replicates the latched A[msb].
  - DATA2 ≥ WIDTH gives 0 (SL) or all-sign (SRA).
- **ROR:** one bit per cycle, n = DATA2 mod WIDTH.
- **n = 0** for any shift/rotate: RESULT = DATA1.
- **Completion:** RESULT and all flags load together at the DONE edge. They do not change at any other time except reset.
- **START while BUSY=1:** ignored. Not queued, no side effect.
- **Back-to-back:** START is sampled in the DONE cycle (BUSY=0 there) and is accepted at that edge.
- **Reset (RESET=0, any time, including mid-operation):**
  - state ← IDLE; BUSY, DONE, RESULT, ZERO, CARRY, OVERFLOW ← 0; counters ← 0.
  - The in-flight operation is discarded and produces no DONE.
  - The first START after reset release is handled normally.

## Timing
- START accepted at edge k. BUSY=1 after edge k for exactly L cycles. DONE=1 and valid RESULT after edge k+L. DONE and BUSY are never high together.
- Latency L:
  - FORWARD / ADD / AND / OR: L = 1.
  - SL / SRA / ROR: L = 1 + n.
  - MULT: L = WIDTH.
- DONE is high for exactly one cycle per accepted operation.
- Maximum sustained throughput: one op per L+1 cycles. The DONE cycle doubles as the next accept cycle.
- No combinational path from any input to any output.

## Test plan (WIDTH=8)
- ADD 0x7F+0x01 -> after 1 BUSY cycle DONE; RESULT=0x80, OVERFLOW=1, CARRY=0, ZERO=0. Then ADD 0xFF+0x01 -> RESULT=0x00, ZERO=1, CARRY=1, OVERFLOW=0.
- MULT 0xFD×0x05 -> BUSY 8 cycles, RESULT=0xF1 (−15). MULT 0x80×0xFF -> RESULT=0x80. Change DATA1/DATA2 while BUSY -> result unaffected. All flags except ZERO are 0.
- Shifts, each checking BUSY length:
  - SRA 0x90 by 3 -> L=4, RESULT=0xF2.
  - SL 0x81 by 9 -> L=9, RESULT=0x00, ZERO=1.
  - ROR 0x81 by 9 -> L=2, RESULT=0xC0.
  - SL 0x5A by 0 -> L=1, RESULT=0x5A.
- START pulsed every cycle during a MULT -> only one DONE; RESULT matches the first operands. START held high through the DONE cycle with AND 0xF0&0x3C -> accepted immediately; next DONE gives 0x30.
- FORWARD DATA2=0xA5 -> RESULT=0xA5 after 1 cycle. OR 0x0F|0xF0 -> 0xFF.
- RESET low mid-MULT (cycle 4) -> all outputs 0 immediately, no DONE. After release, ADD 0x02+0x03 -> RESULT=0x05 with normal latency.
